// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver (LSB first) with a 16x oversampling tick divider and a
// two-flop input synchronizer; emits one-cycle byte and framing-error strobes.
module uart_rx_os16 #(
  parameter int DIVISOR   = 163,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int             TW        = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [TW-1:0]  TICK_MAX  = TW'(DIVISOR - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);
  localparam int             SHIFT     = 8 - DATA_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic [1:0]    r_sync;
  logic [TW-1:0] r_tick_cnt;
  state_t        r_state;
  logic [3:0]    r_s;
  logic [2:0]    r_n;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic          r_done;
  logic          r_err;

  logic          w_rx_s;
  logic          w_tick;
  state_t        w_state_nxt;
  logic [3:0]    w_s_nxt;
  logic [2:0]    w_n_nxt;
  logic [7:0]    w_sh_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_done_nxt;
  logic          w_err_nxt;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_tick_cnt == TICK_MAX);

  // Synchronizer idles high so reset release never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // Free-running divider; frame events never realign it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_sh    <= w_sh_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_sh_nxt    = r_sh;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_s_nxt     = '0;
        end
      end

      S_START: begin
        if (w_tick) begin
          if (r_s == 4'd7) begin
            if (!w_rx_s) begin
              w_state_nxt = S_DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (w_tick) begin
          if (r_s == 4'd15) begin
            w_sh_nxt = {w_rx_s, r_sh[7:1]};
            w_s_nxt  = '0;
            w_n_nxt  = r_n + 3'd1;
            if (r_n == LAST_BIT) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (w_tick) begin
          if (r_s == 4'd15) begin
            if (w_rx_s) begin
              // Short frames land in the top bits of the shifter; right-align them.
              w_data_nxt  = r_sh >> SHIFT;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_WAIT_HIGH;
            end
          end else begin
            w_s_nxt = r_s + 4'd1;
          end
        end
      end

      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign frame_err = r_err;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16 at DIVISOR=4 (64 clk per bit): directed table, corner
// sequences, and random frames scored against a frame-level reference model.
module tb_uart_rx_os16;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic       rx7     = 1'b1;
  logic [7:0] rx_data, rx_data7;
  logic       rx_done, rx_done7;
  logic       frame_err, frame_err7;

  always #5 clk = ~clk;

  uart_rx_os16 #(.DIVISOR(DIV), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  uart_rx_os16 #(.DIVISOR(DIV), .DATA_BITS(7)) dut7 (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx7),
    .rx_data   (rx_data7),
    .rx_done   (rx_done7),
    .frame_err (frame_err7)
  );

  typedef struct {
    bit          inst;
    bit          err;
    logic [7:0]  data;
    int unsigned cyc;
  } evt_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         low_bits;
    int         idle_bits;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  evt_t        obs_q[$];
  evt_t        exp_q[$];
  vec_t        vecs[5];
  int unsigned cyc       = 0;
  int          both_high = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  logic [7:0]  last_good8 = 8'h00;
  logic [7:0]  last_good7 = 8'h00;

  // Event monitor: samples strobes on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    evt_t e;
    cyc <= cyc + 1;
    if (rx_done || frame_err) begin
      e.inst = 1'b0; e.err = frame_err; e.data = rx_data; e.cyc = cyc;
      obs_q.push_back(e);
    end
    if (rx_done7 || frame_err7) begin
      e.inst = 1'b1; e.err = frame_err7; e.data = rx_data7; e.cyc = cyc;
      obs_q.push_back(e);
    end
    if ((rx_done && frame_err) || (rx_done7 && frame_err7)) both_high <= both_high + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input bit inst, input logic v);
    if (inst) rx7 = v;
    else      rx  = v;
  endtask

  // Drives start, nb data bits LSB first, then the stop level; leaves the line at the stop level.
  task automatic send_frame(input bit inst, input logic [7:0] d, input bit stop, input int nb);
    set_line(inst, 1'b0);
    wait_clks(BIT);
    for (int i = 0; i < nb; i++) begin
      set_line(inst, d[i]);
      wait_clks(BIT);
    end
    set_line(inst, stop);
    wait_clks(BIT);
  endtask

  // Reference model: a good frame delivers the low nb bits; a bad stop reports the last good byte.
  task automatic model_frame(input bit inst, input logic [7:0] d, input bit stop, input int nb);
    evt_t       e;
    logic [7:0] mask;
    mask   = 8'hFF >> (8 - nb);
    e.inst = inst;
    e.cyc  = 0;
    e.err  = !stop;
    if (stop) begin
      e.data = d & mask;
      if (inst) last_good7 = e.data;
      else      last_good8 = e.data;
    end else begin
      e.data = inst ? last_good7 : last_good8;
    end
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d_inst", tag, i), {31'd0, obs_q[i].inst}, {31'd0, exp_q[i].inst});
      check($sformatf("%s_ev%0d_err",  tag, i), {31'd0, obs_q[i].err},  {31'd0, exp_q[i].err});
      check($sformatf("%s_ev%0d_data", tag, i), {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0;
    int          lat;
    logic [7:0]  d;
    bit          stop;
    int          hold;
    int          gap;

    vecs[0] = '{8'h55, 1'b0, 10, 2, 1'b1, 8'h5A};
    vecs[1] = '{8'h33, 1'b1,  0, 2, 1'b0, 8'h33};
    vecs[2] = '{8'h00, 1'b1,  0, 0, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1,  0, 0, 1'b0, 8'hFF};
    vecs[4] = '{8'hA5, 1'b1,  0, 3, 1'b0, 8'hA5};

    // Reset state
    wait_clks(4);
    check("reset_rx_data",   {24'd0, rx_data}, 32'h0);
    check("reset_rx_done",   {31'd0, rx_done}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    reset_n = 1'b1;
    wait_clks(2 * BIT);

    // Single frame 0x41 with latency measurement
    c0 = cyc;
    send_frame(1'b0, 8'h41, 1'b1, 8);
    model_frame(1'b0, 8'h41, 1'b1, 8);
    wait_clks(2 * BIT);
    if (obs_q.size() > 0) begin
      lat = int'(obs_q[0].cyc - c0);
      check("t1_latency", lat, (lat >= 604 && lat <= 618) ? lat : 611);
    end
    compare_events("t1");

    // Start glitch shorter than the mid-start sample, then a real frame
    rx = 1'b0;
    wait_clks(16);
    rx = 1'b1;
    wait_clks(3 * BIT);
    check("glitch_no_event", obs_q.size(), 0);
    send_frame(1'b0, 8'h5A, 1'b1, 8);
    model_frame(1'b0, 8'h5A, 1'b1, 8);
    wait_clks(2 * BIT);
    compare_events("glitch");

    // Directed table: bad stop with held break, recovery, back-to-back frames
    for (int i = 0; i < 5; i++) begin
      evt_t e;
      send_frame(1'b0, vecs[i].data, vecs[i].stop, 8);
      if (vecs[i].low_bits > 0) wait_clks(vecs[i].low_bits * BIT);
      rx = 1'b1;
      wait_clks(vecs[i].idle_bits * BIT);
      e.inst = 1'b0; e.err = vecs[i].exp_err; e.data = vecs[i].exp_data; e.cyc = 0;
      exp_q.push_back(e);
    end
    wait_clks(BIT);
    compare_events("table");
    last_good8 = vecs[4].exp_data;

    // Reset during data bit 3 of 0x81
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 3; i++) begin
      d  = 8'h81;
      rx = d[i];
      wait_clks(BIT);
    end
    rx = 1'b0;
    wait_clks(BIT / 2);
    reset_n = 1'b0;
    rx      = 1'b1;
    #1;
    check("midreset_rx_data",   {24'd0, rx_data},   32'h0);
    check("midreset_rx_done",   {31'd0, rx_done},   32'h0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'h0);
    wait_clks(3);
    reset_n = 1'b1;
    last_good8 = 8'h00;
    last_good7 = 8'h00;
    wait_clks(3 * BIT);
    check("midreset_no_event", obs_q.size(), 0);
    send_frame(1'b0, 8'h7E, 1'b1, 8);
    model_frame(1'b0, 8'h7E, 1'b1, 8);
    wait_clks(2 * BIT);
    compare_events("after_reset");

    // Seven data bits, then a few random seven-bit frames
    send_frame(1'b1, 8'h2A, 1'b1, 7);
    model_frame(1'b1, 8'h2A, 1'b1, 7);
    rx7 = 1'b1;
    wait_clks(2 * BIT);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_frame(1'b1, d, 1'b1, 7);
      model_frame(1'b1, d, 1'b1, 7);
      rx7 = 1'b1;
      wait_clks($urandom_range(2) * BIT);
    end
    wait_clks(2 * BIT);
    compare_events("bits7");

    // Random eight-bit frames with occasional framing errors and breaks
    for (int i = 0; i < 10; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      send_frame(1'b0, d, stop, 8);
      model_frame(1'b0, d, stop, 8);
      if (!stop) begin
        hold = $urandom_range(3);
        wait_clks(hold * BIT);
        gap = 1 + $urandom_range(1);
      end else begin
        gap = $urandom_range(2);
      end
      rx = 1'b1;
      wait_clks(gap * BIT);
    end
    wait_clks(2 * BIT);
    compare_events("random");

    check("never_both_high", both_high, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
